// File: rtl/timer_pkg.sv
// Shared constants for the 1 s timebase.
//   TICKS_PER_SEC : system clock cycles per second (default divider)
//   SEC_PER_MIN   : wrap limit of the seconds counter
//   SEC_W         : width of the seconds output
package timer_pkg;

  localparam int unsigned TICKS_PER_SEC = 60;
  localparam int unsigned SEC_PER_MIN   = 60;
  localparam int unsigned SEC_W         = 6;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with hold enable and synchronous active-high reset.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high, priority over en
//   en   : advance on this edge when 1, hold when 0
//   q    : current value, 0..N-1 (registered)
//   wrap : combinational, high while q == N-1
module mod_n_counter #(
  parameter int unsigned N = 60,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         wrap
);

  assign wrap = (q == W'(N - 1));

  // Count 0..N-1 and roll over on the last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= wrap ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/timer_1seg.sv
// Divides the system clock down to a 1 Hz timebase.
// Optional macro TIMER_1SEG_SEC_COUNT_EN enables the 0..59 seconds counter;
// without it sec is tied to 0 and no seconds flops exist.
// Ports:
//   clk     : system clock (60 Hz nominal), rising edge
//   rst     : synchronous reset, active-high, priority over en
//   en      : count enable; when 0 all state holds and tick is 0
//   clk_out : registered 50%-duty square wave, one period per DIV cycles
//   tick    : registered one-cycle strobe after each completed period
//   count   : current phase 0..DIV-1
//   sec     : seconds 0..59 (0 when the seconds feature is disabled)
module timer_1seg
  import timer_pkg::*;
#(
  parameter int unsigned DIV   = TICKS_PER_SEC,
  parameter int unsigned CNT_W = $clog2(DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic [SEC_W-1:0] sec
);

  localparam int unsigned HALF = DIV / 2;

  logic phase_wrap;

  mod_n_counter #(
    .N (DIV),
    .W (CNT_W)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .q    (count),
    .wrap (phase_wrap)
  );

  // Rise entering the second half of the period, fall on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_out <= 1'b0;
    end else if (en) begin
      if (phase_wrap) begin
        clk_out <= 1'b0;
      end else if (count == CNT_W'(HALF - 1)) begin
        clk_out <= 1'b1;
      end
    end
  end

  // Strobe is recomputed every edge so it can never persist.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= en & phase_wrap;
    end
  end

`ifdef TIMER_1SEG_SEC_COUNT_EN
  logic sec_wrap;

  mod_n_counter #(
    .N (SEC_PER_MIN),
    .W (SEC_W)
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .en   (en & phase_wrap),
    .q    (sec),
    .wrap (sec_wrap)
  );
`else
  assign sec = '0;
`endif

endmodule

// File: tb/tb_timer_1seg.sv
// Self-checking bench for timer_1seg: a DIV=60 and a DIV=5 instance share
// rst/en and are compared each cycle against a model built on the number of
// enabled edges since reset.
module tb_timer_1seg;
  import timer_pkg::*;

  localparam int unsigned DIV_A = 60;
  localparam int unsigned DIV_B = 5;
  localparam int unsigned W_A   = $clog2(DIV_A);
  localparam int unsigned W_B   = $clog2(DIV_B);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic             clk_out_a, tick_a, clk_out_b, tick_b;
  logic [W_A-1:0]   count_a;
  logic [W_B-1:0]   count_b;
  logic [SEC_W-1:0] sec_a, sec_b;

  timer_1seg #(.DIV(DIV_A)) dut_a (
    .clk (clk), .rst (rst), .en (en),
    .clk_out (clk_out_a), .tick (tick_a), .count (count_a), .sec (sec_a)
  );

  timer_1seg #(.DIV(DIV_B)) dut_b (
    .clk (clk), .rst (rst), .en (en),
    .clk_out (clk_out_b), .tick (tick_b), .count (count_b), .sec (sec_b)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: enabled edges since reset, and whether the last edge was enabled.
  int unsigned m_n       = 0;
  bit          m_last_en = 1'b0;

  function automatic int exp_count(int unsigned div);
    return int'(m_n % div);
  endfunction

  function automatic int exp_clk_out(int unsigned div);
    return ((m_n % div) >= (div / 2)) ? 1 : 0;
  endfunction

  function automatic int exp_tick(int unsigned div);
    return (m_last_en && m_n != 0 && (m_n % div) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_sec(int unsigned div);
`ifdef TIMER_1SEG_SEC_COUNT_EN
    return int'((m_n / div) % SEC_PER_MIN);
`else
    return (div == 0) ? 1 : 0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("count_a",   int'(count_a),   exp_count(DIV_A));
    check("clk_out_a", int'(clk_out_a), exp_clk_out(DIV_A));
    check("tick_a",    int'(tick_a),    exp_tick(DIV_A));
    check("sec_a",     int'(sec_a),     exp_sec(DIV_A));
    check("count_b",   int'(count_b),   exp_count(DIV_B));
    check("clk_out_b", int'(clk_out_b), exp_clk_out(DIV_B));
    check("tick_b",    int'(tick_b),    exp_tick(DIV_B));
    check("sec_b",     int'(sec_b),     exp_sec(DIV_B));
  endtask

  // One clock: drive on the falling edge, update model on the rising edge, sample 1 time unit later.
  task automatic step(input logic r, input logic e, input bit do_check);
    @(negedge clk);
    rst = r;
    en  = e;
    @(posedge clk);
    if (r) begin
      m_n = 0;
      m_last_en = 1'b0;
    end else if (e) begin
      m_n++;
      m_last_en = 1'b1;
    end else begin
      m_last_en = 1'b0;
    end
    #1;
    if (do_check) check_model();
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    int         count;
    int         clk_out;
    int         tick;
  } vec_t;

  vec_t vecs [10];

  localparam int SEC_AT_3599 =
`ifdef TIMER_1SEG_SEC_COUNT_EN
    59;
`else
    0;
`endif

  initial begin
    // Hand-derived DIV=5 vectors: low 2 cycles, high 3, tick on the wrap.
    vecs[0] = '{1'b1, 1'b1, 0, 0, 0};
    vecs[1] = '{1'b0, 1'b1, 1, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 2, 1, 0};
    vecs[3] = '{1'b0, 1'b1, 3, 1, 0};
    vecs[4] = '{1'b0, 1'b1, 4, 1, 0};
    vecs[5] = '{1'b0, 1'b1, 0, 0, 1};
    vecs[6] = '{1'b0, 1'b0, 0, 0, 0};
    vecs[7] = '{1'b0, 1'b1, 1, 0, 0};
    vecs[8] = '{1'b0, 1'b0, 1, 0, 0};
    vecs[9] = '{1'b1, 1'b1, 0, 0, 0};

    // Reset with en=1 held two cycles.
    step(1'b1, 1'b1, 1'b0);
    check("rst_count", int'(count_a), 0);
    check("rst_clk_out", int'(clk_out_a), 0);
    check("rst_tick", int'(tick_a), 0);
    check("rst_sec", int'(sec_a), 0);
    step(1'b1, 1'b1, 1'b1);

    // Directed table on the DIV=5 instance.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rst, vecs[i].en, 1'b1);
      check($sformatf("vec%0d_count", i), int'(count_b), vecs[i].count);
      check($sformatf("vec%0d_clk_out", i), int'(clk_out_b), vecs[i].clk_out);
      check($sformatf("vec%0d_tick", i), int'(tick_b), vecs[i].tick);
    end

    // Free run 120 enabled edges from reset.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 120; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (i == 29) check("run_e29_clk_out", int'(clk_out_a), 0);
      if (i == 30) check("run_e30_clk_out", int'(clk_out_a), 1);
      if (i == 59) check("run_e59_tick", int'(tick_a), 0);
      if (i == 60) begin
        check("run_e60_tick", int'(tick_a), 1);
        check("run_e60_clk_out", int'(clk_out_a), 0);
      end
      if (i == 120) check("run_e120_tick", int'(tick_a), 1);
    end

    // Enable gating at phase 25.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    check("gate_count", int'(count_a), 25);
    check("gate_clk_out", int'(clk_out_a), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check("gate_e4_clk_out", int'(clk_out_a), 0);
    step(1'b0, 1'b1, 1'b1);
    check("gate_e5_clk_out", int'(clk_out_a), 1);

    // Reset mid-period while clk_out is high.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 45; i++) step(1'b0, 1'b1, 1'b1);
    check("mid_pre_clk_out", int'(clk_out_a), 1);
    step(1'b1, 1'b1, 1'b1);
    check("mid_count", int'(count_a), 0);
    check("mid_clk_out", int'(clk_out_a), 0);
    check("mid_tick", int'(tick_a), 0);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1, 1'b1);
    check("mid_e59_tick", int'(tick_a), 0);
    step(1'b0, 1'b1, 1'b1);
    check("mid_e60_tick", int'(tick_a), 1);

    // One full minute of enabled edges.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3599; i++) step(1'b0, 1'b1, 1'b1);
    check("min_e3599_sec", int'(sec_a), SEC_AT_3599);
    step(1'b0, 1'b1, 1'b1);
    check("min_e3600_sec", int'(sec_a), 0);
    check("min_e3600_tick", int'(tick_a), 1);

    // Random enable with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
